// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v counters with registered sync, blanking and position outputs.
// Optional frame counter port is built when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       RST,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [9:0] xPos,
    output logic [9:0] yPos,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_q, blank_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       fs_q, fs_d;

    always_comb begin
        h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        // Outputs describe the counter state being left on this edge.
        hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));
        blank_d = (h_q < H_ACT) && (v_q < V_ACT);
        x_d     = blank_d ? h_q : 10'd0;
        y_d     = blank_d ? v_q : 10'd0;
        fs_d    = (h_q == 10'd0) && (v_q == 10'd0);
    end

    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_q;
    assign xPos        = x_q;
    assign yPos        = y_q;
    assign frame_start = fs_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] fcnt_q, fcnt_d;
    logic       seen_q, seen_d;

    // Frame 0 after reset keeps the count at zero; later frame starts bump it.
    always_comb begin
        fcnt_d = (fs_d && seen_q) ? fcnt_q + 8'd1 : fcnt_q;
        seen_d = seen_q | fs_d;
    end

    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            fcnt_q <= 8'd0;
            seen_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            seen_q <= seen_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, medium, 4x4 timing)
// checked every cycle against a pixel-index model, with random resets.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned k        = 0;

    localparam int FB = (16+2+4+3) * (12+2+2+3);
    localparam int FC = 7 * 7;

    logic       a_hs, a_vs, a_bl, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_bl, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_hs, c_vs, c_bl, c_fs;
    logic [9:0] c_x, c_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc, c_fc;
`endif

    vga_sync_gen u_a (
        .vga_clk(clk), .RST(rst_n),
        .hsync(a_hs), .vsync(a_vs), .blank_n(a_bl),
        .xPos(a_x), .yPos(a_y), .frame_start(a_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
       ,.frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (
        .vga_clk(clk), .RST(rst_n),
        .hsync(b_hs), .vsync(b_vs), .blank_n(b_bl),
        .xPos(b_x), .yPos(b_y), .frame_start(b_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
       ,.frame_cnt(b_fc)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (
        .vga_clk(clk), .RST(rst_n),
        .hsync(c_hs), .vsync(c_vs), .blank_n(c_bl),
        .xPos(c_x), .yPos(c_y), .frame_start(c_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
       ,.frame_cnt(c_fc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    // Edge kk (1-based since release) shows pixel index kk-1 of the raster.
    function automatic logic [23:0] model(input int unsigned kk,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb);
        int ht;
        int vt;
        int p;
        int h;
        int v;
        logic act;
        logic [9:0] xh;
        logic [9:0] yv;
        if (kk == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 20'd0};
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        p   = int'((kk - 1) % (ht * vt));
        h   = p % ht;
        v   = p / ht;
        act = (h < ha) && (v < va);
        xh  = act ? 10'(h) : 10'd0;
        yv  = act ? 10'(v) : 10'd0;
        return {!(h >= ha+hf && h < ha+hf+hs),
                !(v >= va+vf && v < va+vf+vs),
                act, (p == 0), xh, yv};
    endfunction

    function automatic logic [7:0] fc_model(input int unsigned kk,
                                            input int f);
        if (kk == 0) return 8'd0;
        return 8'((kk - 1) / f);
    endfunction

    int unsigned st_bl, st_hs, st_vs, st_fs;

    task automatic check_all();
        check("dut_a", {8'd0, a_hs, a_vs, a_bl, a_fs, a_x, a_y},
              {8'd0, model(k, 640, 16, 96, 48, 480, 10, 2, 33)});
        check("dut_b", {8'd0, b_hs, b_vs, b_bl, b_fs, b_x, b_y},
              {8'd0, model(k, 16, 2, 4, 3, 12, 2, 2, 3)});
        check("dut_c", {8'd0, c_hs, c_vs, c_bl, c_fs, c_x, c_y},
              {8'd0, model(k, 4, 1, 1, 1, 4, 1, 1, 1)});
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("fcnt_a", {24'd0, a_fc}, {24'd0, fc_model(k, 420000)});
        check("fcnt_b", {24'd0, b_fc}, {24'd0, fc_model(k, FB)});
        check("fcnt_c", {24'd0, c_fc}, {24'd0, fc_model(k, FC)});
`endif
        if (k == 0) begin
            st_bl = 0; st_hs = 0; st_vs = 0; st_fs = 0;
        end else if (k <= FB) begin
            st_bl += 32'(b_bl);
            st_hs += 32'(!b_hs);
            st_vs += 32'(!b_vs);
            st_fs += 32'(b_fs);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) k++;
            #1;
            check_all();
        end
    endtask

    // Asynchronous reset must take effect before the next clock edge.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        k = 0;
        #1;
        check_all();
        run(n);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_all();
        run(3);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
        for (int s = 0; s < 12; s++) begin
            run(int'($urandom_range(50, 2500)));
            do_reset(int'($urandom_range(1, 4)));
        end
        run(257 * FC + 20);
        check("b_blank_frame", 32'(st_bl), 32'(16 * 12));
        check("b_hsync_frame", 32'(st_hs), 32'(4 * 19));
        check("b_vsync_frame", 32'(st_vs), 32'(2 * 25));
        check("b_fs_frame", 32'(st_fs), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have exactly one clock domain; reset is asynchronous and active-low.
REQ-002 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-003 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-004 Parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-005 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-006 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-007 Parameter V_FP, 10, vertical front porch in lines.
REQ-008 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-009 Parameter V_BP, 33, vertical back porch in lines.
REQ-010 vga_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-011 RST  input  1  asynchronous active-low reset.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 blank_n  output  1  high only for visible pixels.
REQ-015 xPos  output  10  visible column, feeds pattern generators.
REQ-016 yPos  output  10  visible row, feeds pattern generators.
REQ-017 frame_start  output  1  one-cycle pulse on pixel (0,0).
REQ-018 frame_cnt  output  8  frame counter; port exists only under VGA_SYNC_FRAME_CNT_EN.

Function
REQ-019 Internal h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and wrap to 0.
REQ-020 Internal v_cnt SHALL count 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); it advances only when h_cnt wraps and itself wraps to 0.
REQ-021 Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1) SHALL return both counters to 0 on the same edge.
REQ-022 Horizontal phase decode: ACTIVE h<H_ACTIVE; FP; SYNC for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 656..751); BP. Vertical phases decode the same way on v_cnt (default vsync lines 490..491).
REQ-023 All outputs SHALL be registered and SHALL describe the counter state of the previous edge (latency 1); all outputs stay mutually aligned.
REQ-024 blank_n SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 xPos SHALL equal h_cnt and yPos SHALL equal v_cnt when blank_n=1; both SHALL be 0 otherwise.
REQ-026 hsync SHALL be 0 during the horizontal SYNC phase on every line, including vertical blanking lines; vsync SHALL be 0 for whole lines in the vertical SYNC phase.
REQ-027 frame_start SHALL be 1 exactly when the outputs describe h_cnt=0 and v_cnt=0.
REQ-028 Counters SHALL be 10 bits wide; H_TOTAL and V_TOTAL SHALL be at most 1024.

Reset
REQ-029 While RST=0: h_cnt=0, v_cnt=0, hsync=1, vsync=1, blank_n=0, xPos=0, yPos=0, frame_start=0, frame_cnt=0.
REQ-030 The first rising edge after RST deasserts SHALL output pixel (0,0): blank_n=1, frame_start=1.
REQ-031 Reset asserted mid-frame SHALL immediately force the reset values; no partial-frame state is retained.

Configuration
REQ-032 With VGA_SYNC_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on each edge where frame_start is output as 1, except the first frame_start after reset (frame_cnt stays 0 for frame 0), and SHALL wrap 255->0.
REQ-033 Without VGA_SYNC_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent; all other behaviour is unchanged.

Verification
REQ-034 Release reset, then run 1 frame (420000 clocks) -> exactly 307200 clocks with blank_n=1; frame_start pulses at edges 1 and 420001.
REQ-035 Line 0 -> xPos 0..639 while blank_n=1; hsync low for exactly 96 clocks beginning at pixel 656; blank_n low for 160 clocks.
REQ-036 Full frame -> vsync low for exactly 1600 clocks, spanning lines 490-491; hsync keeps pulsing during those lines.
REQ-037 Assert RST at pixel (300,200) for 3 clocks -> outputs equal reset values on the same clock; first edge after release gives xPos=0, yPos=0, frame_start=1.
REQ-038 With VGA_SYNC_FRAME_CNT_EN, run 257 frames -> frame_cnt reads 0, 1, ..., 255, 0; frame_cnt is 0 again in frame 256.
REQ-039 With 4x4 test parameters (H=4/1/1/1, V=4/1/1/1) -> wrap occurs at (6,6)->(0,0) in a single edge, with frame_start asserted.
